// File: rtl/sha256_config_sync_rep.sv
// ---------------------------------------------------------------------------
// sha256_config_sync_rep : joins hash IDs with repeatable message configs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_config_sync_rep #(
  parameter int ID_W     = 6,
  parameter int SIZE_W   = 64,
  parameter int SCHEME_W = 2,
  parameter int CNT_W    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       sync_rst,
  input  logic                       en,
  input  logic [ID_W-1:0]            id_in,
  input  logic                       id_in_last,
  input  logic                       id_in_valid,
  output logic                       id_in_ready,
  input  logic [SIZE_W-1:0]          cfg_in_size,
  input  logic [SCHEME_W-1:0]        cfg_in_scheme,
  input  logic [CNT_W-1:0]           cfg_in_count,
  input  logic                       cfg_in_last,
  input  logic                       cfg_in_valid,
  output logic                       cfg_in_ready,
  output logic [SIZE_W-1:0]          cfg_out_size,
  output logic [SCHEME_W-1:0]        cfg_out_scheme,
  output logic [ID_W-1:0]            cfg_out_id,
  output logic                       cfg_out_last,
  output logic                       cfg_out_valid,
  input  logic                       cfg_out_ready,
  output logic [$clog2(DEPTH):0]     id_level,
  output logic [$clog2(DEPTH):0]     cfg_level,
  output logic                       align_err
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int CFG_W = SIZE_W + SCHEME_W + CNT_W + 1;

  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ID_W:0]      id_mem  [DEPTH];
  logic [CFG_W-1:0]   cfg_mem [DEPTH];
  logic [PW-1:0]      id_wr, id_rd, cfg_wr, cfg_rd;
  logic [CNT_W-1:0]   rep_cnt;

  logic               id_push, cfg_push, id_pop, cfg_pop;
  logic               loadable, join_fire, final_rep, misalign;
  logic [ID_W-1:0]    id_h;
  logic               id_h_last;
  logic [SIZE_W-1:0]  cfg_h_size;
  logic [SCHEME_W-1:0] cfg_h_scheme;
  logic [CNT_W-1:0]   cfg_h_count;
  logic               cfg_h_last;

  // Ready is derived only from registered levels, so a pop never frees a slot
  // for a push in the same cycle.
  assign id_in_ready  = en && (id_level  < LVL_FULL);
  assign cfg_in_ready = en && (cfg_level < LVL_FULL);
  assign id_push      = id_in_valid  && id_in_ready;
  assign cfg_push     = cfg_in_valid && cfg_in_ready;

  assign {id_h, id_h_last} = id_mem[id_rd];
  assign {cfg_h_size, cfg_h_scheme, cfg_h_count, cfg_h_last} = cfg_mem[cfg_rd];

  assign loadable  = !cfg_out_valid || cfg_out_ready;
  assign join_fire = en && (id_level != '0) && (cfg_level != '0) && loadable;
  assign final_rep = (rep_cnt == cfg_h_count);
  assign id_pop    = join_fire;
  assign cfg_pop   = join_fire && final_rep;

  // An ID may close a packet exactly when the last repetition of a closing config does.
  assign misalign  = (final_rep && cfg_h_last) != id_h_last;

  always_ff @(posedge clk) begin
    if (id_push) begin
      id_mem[id_wr] <= {id_in, id_in_last};
    end
    if (cfg_push) begin
      cfg_mem[cfg_wr] <= {cfg_in_size, cfg_in_scheme, cfg_in_count, cfg_in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      id_wr  <= '0;
      id_rd  <= '0;
      cfg_wr <= '0;
      cfg_rd <= '0;
    end else begin
      if (id_push)  id_wr  <= id_wr  + PTR_ONE;
      if (id_pop)   id_rd  <= id_rd  + PTR_ONE;
      if (cfg_push) cfg_wr <= cfg_wr + PTR_ONE;
      if (cfg_pop)  cfg_rd <= cfg_rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      id_level <= '0;
    end else begin
      case ({id_push, id_pop})
        2'b10:   id_level <= id_level + LVL_ONE;
        2'b01:   id_level <= id_level - LVL_ONE;
        default: id_level <= id_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cfg_level <= '0;
    end else begin
      case ({cfg_push, cfg_pop})
        2'b10:   cfg_level <= cfg_level + LVL_ONE;
        2'b01:   cfg_level <= cfg_level - LVL_ONE;
        default: cfg_level <= cfg_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rep_cnt <= '0;
    end else if (join_fire) begin
      rep_cnt <= final_rep ? '0 : rep_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cfg_out_valid  <= 1'b0;
      cfg_out_size   <= '0;
      cfg_out_scheme <= '0;
      cfg_out_id     <= '0;
      cfg_out_last   <= 1'b0;
    end else if (join_fire) begin
      cfg_out_valid  <= 1'b1;
      cfg_out_size   <= cfg_h_size;
      cfg_out_scheme <= cfg_h_scheme;
      cfg_out_id     <= id_h;
      cfg_out_last   <= final_rep && cfg_h_last;
    end else if (loadable) begin
      cfg_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      align_err <= 1'b0;
    end else if (join_fire && misalign) begin
      align_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire
